perceptron_layer_sched: RTL and testbench

Time-multiplexing scheduler that shares one registered perceptron datapath across `N_NEURONS` neurons of a layer. It holds every neuron's eight 8-bit weights and 8-bit bias in a configuration register file. It accepts one 8-bit binary input vector per frame and issues it to the perceptron once per neuron with that neuron's weights. It returns one 8-bit result per neuron on a valid/ready output stream.

---
 rtl/perceptron_pkg.sv | 10 +
 rtl/perceptron_param_rf.sv | 41 ++++
 rtl/perceptron_layer_sched.sv | 133 +++++++++++++
 tb/tb_perceptron_layer_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants and scheduler state type for the time-multiplexed perceptron layer.
package perceptron_pkg;

   localparam int         DATA_W    = 8;
   localparam int         N_INPUTS  = 8;
   localparam logic [3:0] SLOT_BIAS = 4'd8;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, EMIT} sched_state_t;

endpackage

// File: rtl/perceptron_param_rf.sv
// Per-neuron weight/bias register file: one write port, one combinational 72-bit neuron read.
module perceptron_param_rf
   import perceptron_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en_i,
   input  logic [IDX_W-1:0]             wr_neuron_i,
   input  logic [3:0]                   wr_slot_i,
   input  logic [DATA_W-1:0]            wr_data_i,
   input  logic [IDX_W-1:0]             rd_neuron_i,
   output logic [N_INPUTS*DATA_W-1:0]   rd_weights_o,
   output logic [DATA_W-1:0]            rd_bias_o
);

   logic [N_INPUTS*DATA_W-1:0] weights_q [N_NEURONS];
   logic [DATA_W-1:0]          bias_q    [N_NEURONS];

   // Slots above the bias slot are never stored; the caller also filters them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < N_NEURONS; n++) begin
            weights_q[n] <= '0;
            bias_q[n]    <= '0;
         end
      end else if (wr_en_i) begin
         if (wr_slot_i == SLOT_BIAS) begin
            bias_q[wr_neuron_i] <= wr_data_i;
         end else if (!wr_slot_i[3]) begin
            weights_q[wr_neuron_i][int'(wr_slot_i[2:0])*DATA_W +: DATA_W] <= wr_data_i;
         end
      end
   end

   assign rd_weights_o = weights_q[rd_neuron_i];
   assign rd_bias_o    = bias_q[rd_neuron_i];

endmodule

// File: rtl/perceptron_layer_sched.sv
// Sequences one input frame through a shared external perceptron, once per neuron,
// and streams one result per neuron out on a valid/ready port.
module perceptron_layer_sched
   import perceptron_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_neuron,
   input  logic [3:0]         cfg_slot,
   input  logic [7:0]         cfg_data,
   output logic               cfg_drop,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_vec,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic [7:0]         pe_in,
   output logic [63:0]        pe_weights,
   output logic [7:0]         pe_bias,
   input  logic [7:0]         pe_out,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // out_valid and its payload hold until that edge, in_ready is high only while idle.

   localparam logic [IDX_W:0]   N_CNT    = (IDX_W+1)'(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   sched_state_t     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       pe_in_q, pe_in_d;
   logic [7:0]       out_data_q, out_data_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             cfg_drop_q, cfg_drop_d;
   logic             neuron_ok, rf_we;

   assign neuron_ok  = {1'b0, cfg_neuron} < N_CNT;
   assign rf_we      = cfg_we && (state_q == IDLE) && neuron_ok && (cfg_slot <= SLOT_BIAS);
   assign cfg_drop_d = cfg_we && ((state_q != IDLE) || !neuron_ok);

   perceptron_param_rf #(
      .N_NEURONS (N_NEURONS),
      .IDX_W     (IDX_W)
   ) u_rf (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (rf_we),
      .wr_neuron_i  (cfg_neuron),
      .wr_slot_i    (cfg_slot),
      .wr_data_i    (cfg_data),
      .rd_neuron_i  (idx_q),
      .rd_weights_o (pe_weights),
      .rd_bias_o    (pe_bias)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         pe_in_q    <= '0;
         out_data_q <= '0;
         out_idx_q  <= '0;
         out_last_q <= 1'b0;
         cfg_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pe_in_q    <= pe_in_d;
         out_data_q <= out_data_d;
         out_idx_q  <= out_idx_d;
         out_last_q <= out_last_d;
         cfg_drop_q <= cfg_drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pe_in_d    = pe_in_q;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      out_last_d = out_last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pe_in_d = in_vec;
               idx_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = CAPT;
         // pe_out now reflects the operands driven during ISSUE.
         CAPT: begin
            out_data_d = pe_out;
            out_idx_d  = idx_q;
            out_last_d = (idx_q == LAST_IDX);
            state_d    = EMIT;
         end
         EMIT: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == EMIT);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign pe_in     = pe_in_q;
   assign cfg_drop  = cfg_drop_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_perceptron_layer_sched.sv
// Bench for perceptron_layer_sched: a 5-neuron instance with a behavioural perceptron and
// layer model, plus a 1-neuron instance for the single-neuron corner.
module tb_perceptron_layer_sched;
  import perceptron_pkg::*;

  localparam int N  = 5;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (5 neurons) ----------------
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_neuron = '0;
  logic [3:0]    cfg_slot = '0;
  logic [7:0]    cfg_data = '0;
  logic          cfg_drop;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [7:0]    pe_in;
  logic [63:0]   pe_weights;
  logic [7:0]    pe_bias;
  logic [7:0]    pe_out = '0;
  logic          busy;
  logic [1:0]    dbg_state;

  perceptron_layer_sched #(.N_NEURONS(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot), .cfg_data(cfg_data),
    .cfg_drop(cfg_drop),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .pe_in(pe_in), .pe_weights(pe_weights), .pe_bias(pe_bias), .pe_out(pe_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- single-neuron DUT ----------------
  logic        b_cfg_we = 1'b0;
  logic        b_cfg_neuron = 1'b0;
  logic        b_cfg_drop;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic        b_out_idx;
  logic        b_out_last;
  logic [7:0]  b_pe_in;
  logic [63:0] b_pe_weights;
  logic [7:0]  b_pe_bias;
  logic [7:0]  b_pe_out = '0;
  logic        b_busy;
  logic [1:0]  b_dbg_state;

  perceptron_layer_sched #(.N_NEURONS(1)) u_one (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(b_cfg_we), .cfg_neuron(b_cfg_neuron), .cfg_slot(cfg_slot), .cfg_data(cfg_data),
    .cfg_drop(b_cfg_drop),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(in_vec),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last),
    .pe_in(b_pe_in), .pe_weights(b_pe_weights), .pe_bias(b_pe_bias), .pe_out(b_pe_out),
    .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // External perceptron: registered dot product plus bias, wrapping at 8 bits.
  function automatic logic [7:0] pe_model(input logic [7:0] x, input logic [63:0] w,
                                          input logic [7:0] b);
    int s;
    s = int'(b);
    for (int k = 0; k < 8; k++) if (x[k]) s += int'(w[8*k +: 8]);
    return s[7:0];
  endfunction

  always @(posedge clk) begin
    pe_out   <= pe_model(pe_in, pe_weights, pe_bias);
    b_pe_out <= pe_model(b_pe_in, b_pe_weights, b_pe_bias);
  end

  // ---------------- reference model of the layer configuration ----------------
  int sh_w [N][8];
  int sh_b [N];

  function automatic logic [7:0] ref_out(input int n, input logic [7:0] vec);
    int s;
    s = sh_b[n];
    for (int k = 0; k < 8; k++) if (vec[k]) s = s + sh_w[n][k];
    return 8'(s % 256);
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  res [N];
  int frame_cycles;
  int first_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int b = 0;
    while (!in_ready && b < 100) begin
      @(posedge clk); #1; b++;
    end
    if (!in_ready) check("wait_idle_timeout", in_ready, 1);
  endtask

  task automatic cfg_write(input int n, input int slot, input int data, input bit exp_drop);
    cfg_we = 1'b1; cfg_neuron = IW'(n); cfg_slot = 4'(slot); cfg_data = 8'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_drop", cfg_drop, exp_drop);
    if (!exp_drop && slot <= 8 && n < N) begin
      if (slot == 8) sh_b[n] = data; else sh_w[n][slot] = data;
    end
  endtask

  // Issue one frame and drain all N results; co_write asserts the preset cfg write
  // on the same edge as the frame is accepted.
  task automatic run_frame(input logic [7:0] vec, input bit rnd, input bit co_write);
    int got = 0;
    int budget = 0;
    bit hs;
    logic [11:0] act_e, exp_e;
    wait_idle();
    for (int n = 0; n < N; n++) exp_q.push_back({(n == N-1), 3'(n), ref_out(n, vec)});
    in_vec = vec; in_valid = 1'b1; cfg_we = co_write;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    frame_cycles = 0; first_valid = 0;
    while (got < N && budget < 400) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && first_valid == 0) first_valid = frame_cycles + 1;
      hs = out_valid && out_ready;
      act_e = {out_last, out_idx, out_data};
      @(posedge clk); #1;
      frame_cycles++; budget++;
      if (hs) begin
        exp_e = exp_q.pop_front();
        check("result", act_e, exp_e);
        res[got] = act_e[7:0];
        got++;
      end
    end
    out_ready = 1'b0;
    if (got < N) check("frame_timeout", got, N);
    exp_q.delete();
    check("in_ready_after_frame", in_ready, 1);
    check("out_valid_after_frame", out_valid, 0);
  endtask

  task automatic expect_result(input int n, input logic [7:0] vec);
    int b = 0;
    out_ready = 1'b1;
    while (!out_valid && b < 20) begin
      @(posedge clk); #1; b++;
    end
    check("seq_result", {out_valid, out_last, out_idx, out_data},
          {1'b1, (n == N-1), 3'(n), ref_out(n, vec)});
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_pe_in"}, pe_in, 0);
    check({tag, "_cfg_drop"}, cfg_drop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pe_weights"}, pe_weights, 0);
    check({tag, "_pe_bias"}, pe_bias, 0);
  endtask

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] b;
    logic [7:0] vec;
    logic [7:0] exp;
  } tv_t;

  tv_t tbl [6];

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] vec;
    int b;
    bit seen_emit;
    bit any_valid;

    for (int n = 0; n < N; n++) begin
      sh_b[n] = 0;
      for (int k = 0; k < 8; k++) sh_w[n][k] = 0;
    end
    // neuron-1 weights (all equal), bias, input vector, expected result
    tbl[0] = '{8'h40, 8'h05, 8'hFF, 8'h05};
    tbl[1] = '{8'h40, 8'h05, 8'h01, 8'h45};
    tbl[2] = '{8'h01, 8'h00, 8'hFF, 8'h08};
    tbl[3] = '{8'h03, 8'hFE, 8'h0F, 8'h0A};
    tbl[4] = '{8'hFF, 8'h00, 8'h80, 8'hFF};
    tbl[5] = '{8'h10, 8'h01, 8'h00, 8'h01};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    check("one_reset_in_ready", b_in_ready, 1);
    check("one_reset_out_valid", b_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-neuron instance: weights all 1, in_vec FF -> 8, last set, 3-cycle latency.
    for (int k = 0; k < 8; k++) begin
      b_cfg_we = 1'b1; b_cfg_neuron = 1'b0; cfg_slot = 4'(k); cfg_data = 8'd1;
      @(posedge clk); #1;
    end
    b_cfg_we = 1'b1; b_cfg_neuron = 1'b1; cfg_slot = 4'd8; cfg_data = 8'd9;
    @(posedge clk); #1;
    b_cfg_we = 1'b0;
    check("one_drop_range", b_cfg_drop, 1);
    in_vec = 8'hFF; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b = 1;
    while (!b_out_valid && b < 10) begin
      @(posedge clk); #1; b++;
    end
    check("one_latency", b, 3);
    check("one_result", {b_out_last, b_out_idx, b_out_data}, {1'b1, 1'b0, 8'd8});
    check("one_in_ready_busy", {b_in_ready, b_busy}, 2'b01);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("one_in_ready_back", {b_in_ready, b_out_valid}, 2'b10);

    // Table-driven neuron-1 vectors.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) cfg_write(1, k, int'(tbl[i].w), 0);
      cfg_write(1, 8, int'(tbl[i].b), 0);
      run_frame(tbl[i].vec, 0, 0);
      check("tbl_neuron1", res[1], tbl[i].exp);
      check("tbl_cycles", frame_cycles, 3*N);
      check("tbl_first_valid", first_valid, 3);
    end

    // Biases 10,20,..., weights zero: results in index order, last only on final neuron.
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < 8; k++) cfg_write(n, k, 0, 0);
      cfg_write(n, 8, 10*(n+1), 0);
    end
    run_frame(8'($urandom), 0, 0);
    for (int n = 0; n < N; n++) check("bias_seq", res[n], 10*(n+1));
    check("bias_cycles", frame_cycles, 3*N);

    // Rejected and ignored writes leave the register file unchanged.
    cfg_write(5, 8, 8'h99, 1);
    @(posedge clk); #1;
    check("drop_pulse_ends", cfg_drop, 0);
    cfg_write(7, 0, 8'h99, 1);
    cfg_write(2, 12, 8'h99, 0);
    cfg_write(3, 2, 8'h21, 0);
    run_frame(8'h5C, 0, 0);

    // Write and frame accepted on the same edge: first issue sees the new bias.
    cfg_neuron = 3'd0; cfg_slot = 4'd8; cfg_data = 8'h77;
    sh_b[0] = 8'h77;
    run_frame(8'hA3, 0, 1);
    check("co_write_neuron0", res[0], ref_out(0, 8'hA3));
    check("co_write_no_drop", cfg_drop, 0);

    // Back-pressure during EMIT of idx 2, with a rejected write while busy.
    wait_idle();
    vec = 8'($urandom);
    in_vec = vec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    b = 0;
    while (!(out_valid && out_idx == 3'd2) && b < 100) begin
      @(posedge clk); #1; b++;
    end
    out_ready = 1'b0;
    check("hold_reach_idx2", {out_valid, out_idx}, {1'b1, 3'd2});
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_slot = 4'd8; cfg_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check("hold_payload", {out_valid, out_idx, out_data}, {1'b1, 3'd2, ref_out(2, vec)});
      check("hold_ctrl", {in_ready, busy, dbg_state}, {1'b0, 1'b1, EMIT});
      check("hold_drop", cfg_drop, (i == 0));
    end
    expect_result(2, vec);
    expect_result(3, vec);
    expect_result(4, vec);
    out_ready = 1'b0;
    check("hold_frame_done", in_ready, 1);
    run_frame(8'hFF, 0, 0);
    check("busy_write_ignored", res[0], ref_out(0, 8'hFF));

    // Reset during CAPT of idx 1: everything clears, frame abandoned, weights back to 0.
    wait_idle();
    in_vec = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    b = 0; seen_emit = 1'b0;
    while (!(seen_emit && dbg_state == CAPT) && b < 50) begin
      if (out_valid) seen_emit = 1'b1;
      @(posedge clk); #1; b++;
    end
    check("rst_reach_capt1", dbg_state, CAPT);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < N; n++) begin
      sh_b[n] = 0;
      for (int k = 0; k < 8; k++) sh_w[n][k] = 0;
    end
    any_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) any_valid = 1'b1;
    end
    out_ready = 1'b0;
    check("midrst_no_valid", any_valid, 0);
    run_frame(8'hFF, 0, 0);
    for (int n = 0; n < N; n++) check("midrst_zero", res[n], 0);

    // Randomized configuration and frames with random back-pressure.
    for (int f = 0; f < 12; f++) begin
      int nw;
      nw = $urandom_range(0, 8);
      for (int w = 0; w < nw; w++) begin
        int n;
        n = $urandom_range(0, 7);
        cfg_write(n, $urandom_range(0, 15), $urandom_range(0, 255), n >= N);
      end
      run_frame(8'($urandom), 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
